ipd_frame_parser: RTL and testbench
===================================

# ipd_frame_parser

Byte-level parser that sits directly upstream of the angle-conversion stage in the ESP8266 receive path. It consumes bytes from the UART receiver and recognises ESP8266 `+IPD,<len>:<payload>` notifications. It validates a 3-character ASCII angle payload and drives the 24-bit `ReceiveMessage` word, which the conversion stage turns into `SetAngleOut`. Malformed, out-of-range or stalled frames are dropped, and the last good message is held.

## Interface
- `CLK_FREQ`, 50_000_000: clock frequency in Hz, for documentation only.
- `TIMEOUT_CYC`, 500_000: inter-byte gap in cycles (10 ms at 50 MHz) that aborts a partial frame.
- `MAX_ANGLE`, 180: largest accepted decimal payload value.
- `Clk`, input, 1: system clock; all logic on the rising edge.
- `Rst_n`, input, 1: asynchronous, active-low reset.
- `Rx_Data`, input, 8: received byte; valid only when `Rx_Done` is high.
- `Rx_Done`, input, 1: one-cycle strobe per received byte; may be high on consecutive cycles.
- `ReceiveMessage`, output, 24: last accepted payload as ASCII, first char in [23:16].
- `Msg_Valid`, output, 1: one-cycle pulse when `ReceiveMessage` is updated.
- `Frame_Err`, output, 1: one-cycle pulse when a frame is discarded.

## Operation
- **Reset values:**
  - `ReceiveMessage` = 24'h303930 ("090"), so the downstream angle stage resets to 90.
  - `Msg_Valid` = 0, `Frame_Err` = 0, state = `S_HUNT`, all counters = 0.
- **State machine:** `S_HUNT`, `S_LEN`, `S_PAY`. Bytes are examined only on cycles where `Rx_Done` is high.
- **`S_HUNT`:**
  - `hdr_idx` (0..4) tracks the match against "+IPD,".
  - Matching byte: `hdr_idx` increments.
  - Mismatch: `hdr_idx` goes to 1 if the byte is '+', otherwise to 0.
  - Match at `hdr_idx` = 4 (the ','): go to `S_LEN`, clear `len` and `len_digits`.
  - Stray bytes, including the "\r\n" trailers, are silently ignored here.
- **`S_LEN`:**
  - Digit '0'..'9': `len` = `len`*10 + digit, saturating at 127; `len_digits` increments, saturating at 3.
  - ':' with `len_digits` ≥ 1 and `len` ≥ 1: go to `S_PAY` and clear `pay_cnt`.
  - Any other byte, or ':' with no digits or with `len` = 0: `Frame_Err`, go to `S_HUNT`.
- **`S_PAY`:**
  - Each byte increments `pay_cnt`.
  - The first 3 bytes are shifted into `pay_buf` [23:0], left-shift with the new byte at [7:0].
  - `all_dig` is cleared if any of those 3 bytes is a non-digit.
  - When `pay_cnt` reaches `len`: evaluate the frame and return to `S_HUNT`.
- **Acceptance:** the frame is accepted only if all of these hold:
  - `len` == 3;
  - `all_dig` is set;
  - the decimal value (d2*100 + d1*10 + d0, 10-bit) ≤ `MAX_ANGLE`.
- **On acceptance:** `ReceiveMessage` ← `pay_buf` and `Msg_Valid` pulses.
- **On rejection:** `ReceiveMessage` is unchanged and `Frame_Err` pulses.
- **Timeout:**
  - `gap_cnt` clears on every `Rx_Done` and otherwise counts, saturating.
  - It is active when state ≠ `S_HUNT`, or when `hdr_idx` ≠ 0.
  - When `gap_cnt` reaches `TIMEOUT_CYC - 1`: `Frame_Err` pulses (only if state ≠ `S_HUNT`), then go to `S_HUNT` with `hdr_idx` = 0.
- **Simultaneous events:**
  - `Rx_Done` and timeout expiry in the same cycle: the byte wins; the counter clears and the byte is processed normally.
  - Frame end and the header of the next frame can never share a byte.
- `Msg_Valid` and `Frame_Err` are never high in the same cycle.
- **Reset mid-frame:** everything returns to reset values immediately; the partial frame is lost and the held message reverts to "090".

## Timing
- All outputs are registered.
- `Msg_Valid`/`Frame_Err` go high in the cycle after the `Rx_Done` of the deciding byte; `ReceiveMessage` changes in that same cycle.
- Back-to-back `Rx_Done` on every cycle is sustained with no byte loss.
- The downstream stage sees the new word one cycle after `Msg_Valid` rises; the word stays stable until the next accepted frame.
- Timeout abort is exactly `TIMEOUT_CYC` cycles after the last `Rx_Done`.

## Structure
- Shared package `ipd_pkg` holds:
  - the state enum `ipd_state_t` (`S_HUNT`, `S_LEN`, `S_PAY`);
  - ASCII constants `ASC_PLUS`, `ASC_COLON`, `ASC_0`, `ASC_9`;
  - the 5-byte header constant `IPD_HDR` = "+IPD,";
  - the function `is_digit(byte)`;
  - the reset word `MSG_RST` = 24'h303930.
- No sub-module: the FSM, counters and range check form a single module of about 200 lines.

## Test plan
- **Reset:** assert `Rst_n`=0, then release → `ReceiveMessage`=24'h303930; `Msg_Valid`=0; `Frame_Err`=0.
- **Good frame, back-to-back:** bytes "+IPD,3:135\r\n" with `Rx_Done` on consecutive cycles → exactly one `Msg_Valid` pulse, one cycle after '5'; `ReceiveMessage`=24'h313335.
- **Rejected frames:** each of "+IPD,3:181", "+IPD,3:1a5", "+IPD,4:1234" and "+IPD,:123" → one `Frame_Err` pulse each; `ReceiveMessage` stays at the prior value.
- **Partial header and noise:** "++IPD,3:045" preceded by noise bytes "AT\r\nOK" → accepted; `ReceiveMessage`=24'h303435.
- **Timeout:** send "+IPD,3:0", wait `TIMEOUT_CYC` idle cycles → one `Frame_Err`. A following "+IPD,3:000" is then accepted. A gap of `TIMEOUT_CYC` − 1 cycles mid-payload → no abort.
- **Reset mid-frame:** pulse `Rst_n` low during the payload of "+IPD,3:170" after a prior accept of "120" → `ReceiveMessage` returns to "090". The remaining bytes produce no `Msg_Valid`.

Source files
------------

// File: rtl/ipd_pkg.sv
`default_nettype none
//==============================================================================
// Module   : ipd_pkg
// Purpose  : Shared types and constants for the ESP8266 "+IPD,<len>:<payload>"
//            frame parser: FSM state enum, ASCII constants, header string,
//            reset message word and small character helpers.
// Revision : 1.0 - initial release
//==============================================================================
package ipd_pkg;

    typedef enum logic [1:0] {
        S_HUNT = 2'd0,
        S_LEN  = 2'd1,
        S_PAY  = 2'd2
    } ipd_state_t;

    localparam logic [7:0]  ASC_PLUS  = 8'h2B;
    localparam logic [7:0]  ASC_COLON = 8'h3A;
    localparam logic [7:0]  ASC_0     = 8'h30;
    localparam logic [7:0]  ASC_9     = 8'h39;

    // "+IPD," with '+' in the most significant byte
    localparam logic [39:0] IPD_HDR   = 40'h2B4950442C;

    // "090": the downstream angle stage comes out of reset at 90 degrees
    localparam logic [23:0] MSG_RST   = 24'h303930;

    function automatic logic is_digit(input logic [7:0] b);
        return (b >= ASC_0) && (b <= ASC_9);
    endfunction

    // Expected header character at match position idx (0..4)
    function automatic logic [7:0] hdr_char(input logic [2:0] idx);
        logic [7:0] c;
        case (idx)
            3'd0:    c = IPD_HDR[39:32];
            3'd1:    c = IPD_HDR[31:24];
            3'd2:    c = IPD_HDR[23:16];
            3'd3:    c = IPD_HDR[15:8];
            default: c = IPD_HDR[7:0];
        endcase
        return c;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ipd_frame_parser.sv
`default_nettype none
//==============================================================================
// Module   : ipd_frame_parser
// Purpose  : Recognises ESP8266 "+IPD,<len>:<payload>" notifications in the
//            UART byte stream, validates a 3-digit ASCII angle (0..MAX_ANGLE)
//            and holds the last accepted payload for the angle-conversion
//            stage. Malformed, out-of-range or stalled frames are dropped.
// Ports    : Clk            - system clock, rising edge
//            Rst_n          - asynchronous active-low reset
//            Rx_Data[7:0]   - received byte, qualified by Rx_Done
//            Rx_Done        - one-cycle strobe per received byte
//            ReceiveMessage - last accepted payload, first char in [23:16]
//            Msg_Valid      - one-cycle pulse when ReceiveMessage updates
//            Frame_Err      - one-cycle pulse when a frame is discarded
// Revision : 1.0 - initial release
//==============================================================================
module ipd_frame_parser
    import ipd_pkg::*;
#(
    parameter int CLK_FREQ    = 50_000_000,
    parameter int TIMEOUT_CYC = 500_000,
    parameter int MAX_ANGLE   = 180
) (
    input  logic        Clk,
    input  logic        Rst_n,
    input  logic [7:0]  Rx_Data,
    input  logic        Rx_Done,
    output logic [23:0] ReceiveMessage,
    output logic        Msg_Valid,
    output logic        Frame_Err
);

    localparam int               c_GAP_W   = $clog2(TIMEOUT_CYC);
    localparam logic [c_GAP_W-1:0] c_GAP_MAX = c_GAP_W'(TIMEOUT_CYC - 1);
    localparam logic [9:0]       c_MAX_VAL = 10'(MAX_ANGLE);

    // CLK_FREQ only documents the timeout scaling; reject nonsense values.
    generate
        if (TIMEOUT_CYC < 2 || CLK_FREQ < 1) begin : g_badParams
            $error("ipd_frame_parser: TIMEOUT_CYC must be >= 2 and CLK_FREQ >= 1");
        end
    endgenerate

    ipd_state_t         r_state, w_stateNext;
    logic [2:0]         r_hdrIdx, w_hdrIdxNext;
    logic [6:0]         r_len, w_lenNext;
    logic [1:0]         r_lenDigits, w_lenDigitsNext;
    logic [6:0]         r_payCnt, w_payCntNext;
    logic [23:0]        r_payBuf, w_payBufNext;
    logic               r_allDig, w_allDigNext;
    logic [c_GAP_W-1:0] r_gapCnt;

    logic               w_abort;     // frame discarded before its payload end
    logic               w_frameEnd;  // last payload byte consumed this cycle
    logic               w_accept;
    logic               w_timeout;
    logic               w_gapActive;
    logic [10:0]        w_lenCalc;
    logic [9:0]         w_value;

    assign w_gapActive = (r_state != S_HUNT) || (r_hdrIdx != 3'd0);
    // A byte arriving on the expiry cycle takes priority over the timeout.
    assign w_timeout   = w_gapActive && !Rx_Done && (r_gapCnt == c_GAP_MAX);
    assign w_lenCalc   = {4'd0, r_len} * 11'd10 + {7'd0, Rx_Data[3:0]};

    //--------------------------------------------------------------------------
    // State register
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= S_HUNT;
        end else begin
            r_state <= w_stateNext;
        end
    end

    //--------------------------------------------------------------------------
    // Next-state and datapath-next logic
    //--------------------------------------------------------------------------
    always_comb begin
        w_stateNext     = r_state;
        w_hdrIdxNext    = r_hdrIdx;
        w_lenNext       = r_len;
        w_lenDigitsNext = r_lenDigits;
        w_payCntNext    = r_payCnt;
        w_payBufNext    = r_payBuf;
        w_allDigNext    = r_allDig;
        w_abort         = 1'b0;
        w_frameEnd      = 1'b0;

        if (Rx_Done) begin
            case (r_state)
                S_HUNT: begin
                    if (Rx_Data == hdr_char(r_hdrIdx)) begin
                        if (r_hdrIdx == 3'd4) begin
                            w_stateNext     = S_LEN;
                            w_hdrIdxNext    = 3'd0;
                            w_lenNext       = 7'd0;
                            w_lenDigitsNext = 2'd0;
                        end else begin
                            w_hdrIdxNext = r_hdrIdx + 3'd1;
                        end
                    end else begin
                        // '+' appears only at the head of the header, so a
                        // restart at position 1 is all the back-off needed.
                        w_hdrIdxNext = (Rx_Data == ASC_PLUS) ? 3'd1 : 3'd0;
                    end
                end
                S_LEN: begin
                    if (is_digit(Rx_Data)) begin
                        w_lenNext = (w_lenCalc > 11'd127) ? 7'd127 : w_lenCalc[6:0];
                        if (r_lenDigits != 2'd3) begin
                            w_lenDigitsNext = r_lenDigits + 2'd1;
                        end
                    end else if (Rx_Data == ASC_COLON && r_lenDigits != 2'd0
                                 && r_len != 7'd0) begin
                        w_stateNext  = S_PAY;
                        w_payCntNext = 7'd0;
                        w_allDigNext = 1'b1;
                    end else begin
                        w_abort     = 1'b1;
                        w_stateNext = S_HUNT;
                    end
                end
                S_PAY: begin
                    w_payCntNext = r_payCnt + 7'd1;
                    if (r_payCnt < 7'd3) begin
                        w_payBufNext = {r_payBuf[15:0], Rx_Data};
                        w_allDigNext = r_allDig & is_digit(Rx_Data);
                    end
                    if (w_payCntNext == r_len) begin
                        w_frameEnd  = 1'b1;
                        w_stateNext = S_HUNT;
                    end
                end
                default: begin
                    w_stateNext = S_HUNT;
                end
            endcase
        end else if (w_timeout) begin
            w_abort      = (r_state != S_HUNT);
            w_stateNext  = S_HUNT;
            w_hdrIdxNext = 3'd0;
        end
    end

    //--------------------------------------------------------------------------
    // Output decision: range check on the freshly completed payload
    //--------------------------------------------------------------------------
    always_comb begin
        w_value  = 10'(w_payBufNext[19:16]) * 10'd100
                 + 10'(w_payBufNext[11:8])  * 10'd10
                 + 10'(w_payBufNext[3:0]);
        w_accept = w_frameEnd && (r_len == 7'd3) && w_allDigNext
                 && (w_value <= c_MAX_VAL);
    end

    //--------------------------------------------------------------------------
    // Datapath, gap counter and registered outputs
    //--------------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_hdrIdx       <= 3'd0;
            r_len          <= 7'd0;
            r_lenDigits    <= 2'd0;
            r_payCnt       <= 7'd0;
            r_payBuf       <= 24'd0;
            r_allDig       <= 1'b0;
            r_gapCnt       <= '0;
            ReceiveMessage <= MSG_RST;
            Msg_Valid      <= 1'b0;
            Frame_Err      <= 1'b0;
        end else begin
            r_hdrIdx    <= w_hdrIdxNext;
            r_len       <= w_lenNext;
            r_lenDigits <= w_lenDigitsNext;
            r_payCnt    <= w_payCntNext;
            r_payBuf    <= w_payBufNext;
            r_allDig    <= w_allDigNext;

            if (Rx_Done || !w_gapActive) begin
                r_gapCnt <= '0;
            end else if (r_gapCnt != c_GAP_MAX) begin
                r_gapCnt <= r_gapCnt + 1'b1;
            end

            if (w_accept) begin
                ReceiveMessage <= w_payBufNext;
            end
            Msg_Valid <= w_accept;
            Frame_Err <= w_abort || (w_frameEnd && !w_accept);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ipd_frame_parser.sv
`default_nettype none
`timescale 1ns/1ps
//==============================================================================
// Module   : tb_ipd_frame_parser
// Purpose  : Self-checking bench for ipd_frame_parser: vector table of whole
//            byte strings, hand-written timing sequences (latency, timeout,
//            reset mid-frame) and random byte streams scored against a
//            stream-level reference parser.
// Revision : 1.0 - initial release
//==============================================================================
module tb_ipd_frame_parser;

    localparam int T = 40;  // shortened timeout so idle waits stay brief

    logic        Clk     = 1'b0;
    logic        Rst_n   = 1'b0;
    logic [7:0]  Rx_Data = 8'd0;
    logic        Rx_Done = 1'b0;
    logic [23:0] ReceiveMessage;
    logic        Msg_Valid;
    logic        Frame_Err;

    ipd_frame_parser #(
        .CLK_FREQ    (50_000_000),
        .TIMEOUT_CYC (T),
        .MAX_ANGLE   (180)
    ) dut (
        .Clk            (Clk),
        .Rst_n          (Rst_n),
        .Rx_Data        (Rx_Data),
        .Rx_Done        (Rx_Done),
        .ReceiveMessage (ReceiveMessage),
        .Msg_Valid      (Msg_Valid),
        .Frame_Err      (Frame_Err)
    );

    always #5 Clk = ~Clk;

    int nChecks = 0;
    int nPass   = 0;

    // Output pulse monitor, sampled on the falling edge
    int          nValid = 0;
    int          nErr   = 0;
    int          nBoth  = 0;
    int          evN    = 0;
    logic [1:0]  evKind [0:4095];
    logic [23:0] evWord [0:4095];

    always @(negedge Clk) begin
        if (Msg_Valid) begin
            nValid        <= nValid + 1;
            evKind[evN]   <= 2'd1;
            evWord[evN]   <= ReceiveMessage;
        end
        if (Frame_Err) begin
            nErr <= nErr + 1;
            evKind[evN + (Msg_Valid ? 1 : 0)] <= 2'd2;
            evWord[evN + (Msg_Valid ? 1 : 0)] <= 24'd0;
        end
        if (Msg_Valid && Frame_Err) nBoth <= nBoth + 1;
        evN <= evN + (Msg_Valid ? 1 : 0) + (Frame_Err ? 1 : 0);
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        Rx_Data = b;
        Rx_Done = 1'b1;
        @(posedge Clk);
        #1;
        Rx_Done = 1'b0;
        idle(gap);
    endtask

    // Text is right-justified in 24 bytes; leading zero bytes are padding.
    task automatic send_txt(input logic [191:0] t, input int gap);
        for (int k = 23; k >= 0; k--) begin
            if (t[8*k +: 8] != 8'h00) send_byte(t[8*k +: 8], gap);
        end
    endtask

    task automatic do_reset();
        Rst_n = 1'b0;
        idle(3);
        Rst_n = 1'b1;
        idle(2);
    endtask

    //--------------------------------------------------------------------------
    // Vector table
    //--------------------------------------------------------------------------
    typedef struct packed {
        logic [191:0] txt;
        logic [1:0]   expValid;
        logic [1:0]   expErr;
        logic [23:0]  expMsg;
    } vec_t;

    function automatic vec_t mk(input logic [191:0] t, input logic [1:0] v,
                                input logic [1:0] e, input logic [23:0] m);
        vec_t r;
        r.txt = t; r.expValid = v; r.expErr = e; r.expMsg = m;
        return r;
    endfunction

    vec_t vecs [12];

    //--------------------------------------------------------------------------
    // Reference parser over a whole byte stream
    //--------------------------------------------------------------------------
    logic [7:0]  stim[$];
    int          expKind[$];
    logic [23:0] expWord[$];

    function automatic bit isdig(input logic [7:0] c);
        return c >= 8'd48 && c <= 8'd57;
    endfunction

    function automatic bit hdr_at(input int i);
        string h;
        h = "+IPD,";
        for (int k = 0; k < 5; k++) if (stim[i+k] != h[k]) return 1'b0;
        return 1'b1;
    endfunction

    // Stream that ends inside a frame is expected to time out with an error.
    task automatic run_model();
        int i, n, len, nd, v;
        i = 0;
        n = stim.size();
        expKind.delete();
        expWord.delete();
        while (i < n) begin
            if (i + 5 <= n && hdr_at(i)) begin
                i += 5;
                len = 0;
                nd  = 0;
                while (i < n && isdig(stim[i])) begin
                    len = len * 10 + (int'(stim[i]) - 48);
                    if (len > 127) len = 127;
                    nd++;
                    i++;
                end
                if (i >= n) begin
                    expKind.push_back(2); expWord.push_back(24'd0);
                    break;
                end
                if (stim[i] == 8'h3A && nd > 0 && len > 0) begin
                    i++;
                    if (i + len > n) begin
                        expKind.push_back(2); expWord.push_back(24'd0);
                        break;
                    end
                    v = 999;
                    if (len == 3 && isdig(stim[i]) && isdig(stim[i+1]) && isdig(stim[i+2]))
                        v = (int'(stim[i]) - 48) * 100 + (int'(stim[i+1]) - 48) * 10
                          + (int'(stim[i+2]) - 48);
                    if (v <= 180) begin
                        expKind.push_back(1);
                        expWord.push_back({stim[i], stim[i+1], stim[i+2]});
                    end else begin
                        expKind.push_back(2); expWord.push_back(24'd0);
                    end
                    i += len;
                end else begin
                    expKind.push_back(2); expWord.push_back(24'd0);
                    i++;
                end
            end else begin
                i++;
            end
        end
    endtask

    task automatic push_str(input string s);
        for (int k = 0; k < s.len(); k++) stim.push_back(s[k]);
    endtask

    task automatic gen_stream(input int nTok);
        string noise, pchars;
        int    v, nd;
        noise  = "AT\r\nOK+I,:0P5";
        pchars = "0123456789a";
        stim.delete();
        for (int t = 0; t < nTok; t++) begin
            case ($urandom_range(0, 3))
                0: begin
                    repeat ($urandom_range(1, 4))
                        stim.push_back(noise[$urandom_range(0, noise.len() - 1)]);
                end
                1, 2: begin
                    push_str("+IPD,3:");
                    v = $urandom_range(0, 199);
                    stim.push_back(8'(48 + v / 100));
                    stim.push_back(($urandom_range(0, 7) == 0) ? 8'h78 : 8'(48 + (v / 10) % 10));
                    stim.push_back(8'(48 + v % 10));
                end
                default: begin
                    push_str("+IPD,");
                    nd = $urandom_range(0, 2);
                    if (nd > 0) stim.push_back(8'(48 + $urandom_range(0, 6)));
                    if (nd > 1) stim.push_back(8'(48 + $urandom_range(0, 9)));
                    stim.push_back(($urandom_range(0, 9) != 0) ? 8'h3A : 8'h5A);
                    repeat ($urandom_range(0, 6))
                        stim.push_back(pchars[$urandom_range(0, pchars.len() - 1)]);
                end
            endcase
        end
    endtask

    //--------------------------------------------------------------------------
    // Main sequence
    //--------------------------------------------------------------------------
    initial begin
        int          bv, be, base, nCmp;
        string       s;
        logic [23:0] held;

        vecs[0]  = mk("+IPD,3:181",              2'd0, 2'd1, 24'h313335);
        vecs[1]  = mk("+IPD,3:1a5",              2'd0, 2'd1, 24'h313335);
        vecs[2]  = mk("+IPD,4:1234",             2'd0, 2'd1, 24'h313335);
        vecs[3]  = mk("+IPD,:123",               2'd0, 2'd1, 24'h313335);
        vecs[4]  = mk("AT\r\nOK++IPD,3:045",     2'd1, 2'd0, 24'h303435);
        vecs[5]  = mk("+IPD,3:180\r\n",          2'd1, 2'd0, 24'h313830);
        vecs[6]  = mk("+IPD,0:",                 2'd0, 2'd1, 24'h313830);
        vecs[7]  = mk("+IPD,3:000",              2'd1, 2'd0, 24'h303030);
        vecs[8]  = mk("+IPD,1:5",                2'd0, 2'd1, 24'h303030);
        vecs[9]  = mk("+IP+IPD,3:099",           2'd1, 2'd0, 24'h303939);
        vecs[10] = mk("+IPD,3:999",              2'd0, 2'd1, 24'h303939);
        vecs[11] = mk("+IPD,3X",                 2'd0, 2'd1, 24'h303939);

        // Reset values
        do_reset();
        check("reset msg",   32'(ReceiveMessage), 32'h303930);
        check("reset valid", 32'(Msg_Valid), 32'd0);
        check("reset err",   32'(Frame_Err), 32'd0);

        // Good frame back-to-back: pulse exactly one cycle after '5'
        s  = "+IPD,3:135\r\n";
        bv = nValid;
        for (int k = 0; k < s.len(); k++) begin
            send_byte(s[k], 0);
            check($sformatf("b2b valid@%0d", k), 32'(Msg_Valid), (k == 9) ? 32'd1 : 32'd0);
            if (k == 9) check("b2b msg", 32'(ReceiveMessage), 32'h313335);
        end
        idle(2);
        check("b2b pulses", 32'(nValid - bv), 32'd1);

        // Table of whole frames
        for (int i = 0; i < 12; i++) begin
            bv = nValid;
            be = nErr;
            send_txt(vecs[i].txt, i % 2);
            idle(3);
            check($sformatf("vec%0d valid", i), 32'(nValid - bv), 32'(vecs[i].expValid));
            check($sformatf("vec%0d err", i),   32'(nErr - be),   32'(vecs[i].expErr));
            check($sformatf("vec%0d msg", i),   32'(ReceiveMessage), 32'(vecs[i].expMsg));
        end

        // Timeout abort exactly T cycles after the last byte
        be = nErr;
        send_txt("+IPD,3:0", 0);
        idle(T - 1);
        check("tmo early", 32'(Frame_Err), 32'd0);
        idle(1);
        check("tmo pulse", 32'(Frame_Err), 32'd1);
        idle(2);
        check("tmo count", 32'(nErr - be), 32'd1);
        bv = nValid;
        send_txt("+IPD,3:000", 0);
        idle(3);
        check("post-tmo valid", 32'(nValid - bv), 32'd1);
        check("post-tmo msg",   32'(ReceiveMessage), 32'h303030);

        // Gap of T-1 idle cycles mid-payload does not abort
        bv = nValid;
        be = nErr;
        send_txt("+IPD,3:1", 0);
        idle(T - 1);
        send_txt("55", 0);
        idle(3);
        check("gap err",   32'(nErr - be),   32'd0);
        check("gap valid", 32'(nValid - bv), 32'd1);
        check("gap msg",   32'(ReceiveMessage), 32'h313535);

        // Partial header times out silently and is forgotten
        bv = nValid;
        be = nErr;
        send_txt("+IP", 0);
        idle(T + 3);
        send_txt("D,3:111", 0);
        idle(3);
        check("hdr-tmo err",   32'(nErr - be),   32'd0);
        check("hdr-tmo valid", 32'(nValid - bv), 32'd0);

        // Reset mid-frame
        send_txt("+IPD,3:120", 0);
        idle(2);
        check("pre-rst msg", 32'(ReceiveMessage), 32'h313230);
        send_txt("+IPD,3:1", 0);
        Rst_n = 1'b0;
        #2;
        check("rst async msg", 32'(ReceiveMessage), 32'h303930);
        idle(2);
        Rst_n = 1'b1;
        idle(1);
        bv = nValid;
        send_txt("70", 0);
        idle(3);
        check("rst rest valid", 32'(nValid - bv), 32'd0);
        check("rst rest msg",   32'(ReceiveMessage), 32'h303930);

        // Random streams against the reference parser
        do_reset();
        held = 24'h303930;
        for (int r = 0; r < 3; r++) begin
            gen_stream(50);
            run_model();
            base = evN;
            for (int k = 0; k < stim.size(); k++)
                send_byte(stim[k], ($urandom_range(0, 2) == 0) ? 0 : $urandom_range(1, 3));
            idle(T + 5);
            check($sformatf("rnd%0d events", r), 32'(evN - base), 32'(expKind.size()));
            nCmp = (evN - base < expKind.size()) ? evN - base : expKind.size();
            for (int k = 0; k < nCmp; k++) begin
                check($sformatf("rnd%0d ev%0d kind", r, k), 32'(evKind[base + k]), 32'(expKind[k]));
                if (expKind[k] == 1) begin
                    check($sformatf("rnd%0d ev%0d word", r, k), 32'(evWord[base + k]), 32'(expWord[k]));
                    held = expWord[k];
                end
            end
            check($sformatf("rnd%0d held", r), 32'(ReceiveMessage), 32'(held));
        end

        check("valid/err exclusive", 32'(nBoth), 32'd0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
